// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: worker-array and frame-buffer write-port bundle for the write-back arbiter
//   req/req_addr/req_data : per-worker result ready, flattened address/data (worker i at i*W +: W)
//   grant                 : one-hot accept pulse back to the served worker
//   mem_wr_en/addr/data   : registered frame-buffer write request
//   mem_ready             : frame buffer accepts when mem_wr_en & mem_ready
//   pixel_count           : writes accepted in the current frame
//   frame_done            : pulse on the accept that completes a frame
//   master = arbiter side, slave = worker array / memory side
interface wb_rr_arbiter_if #(
    parameter int NUM_WORKERS = 16,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8
);
    logic [NUM_WORKERS-1:0]        req;
    logic [NUM_WORKERS*ADDR_W-1:0] req_addr;
    logic [NUM_WORKERS*DATA_W-1:0] req_data;
    logic [NUM_WORKERS-1:0]        grant;
    logic                          mem_wr_en;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_data;
    logic                          mem_ready;
    logic [ADDR_W-1:0]             pixel_count;
    logic                          frame_done;
    modport master (
        input  req, req_addr, req_data, mem_ready,
        output grant, mem_wr_en, mem_addr, mem_data, pixel_count, frame_done
    );
    modport slave (
        output req, req_addr, req_data, mem_ready,
        input  grant, mem_wr_en, mem_addr, mem_data, pixel_count, frame_done
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin write-back arbiter sharing one frame-buffer write port among workers
//   wr_clk         : clock, rising edge
//   wr_n_rst       : synchronous active-low reset
//   wr_frame_start : pulse clearing pixel count and round-robin pointer
//   bus            : worker requests, grant, memory write port, pixel count, frame_done
module wb_rr_arbiter #(
    parameter int NUM_WORKERS  = 16,
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 8,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                 wr_clk,
    input  logic                 wr_n_rst,
    input  logic                 wr_frame_start,
    wb_rr_arbiter_if.master      bus
);
    localparam int IW = $clog2(NUM_WORKERS);
    typedef enum logic {IDLE, WRITE} state_t;
    state_t            state, state_n;
    logic [IW-1:0]     ptr, win, pick, win_next;
    logic [ADDR_W-1:0] addr_q, pc;
    logic [DATA_W-1:0] data_q;
    logic              accept, last;
    // Scan from the farthest slot towards ptr so the closest requester is assigned last and wins.
    always_comb begin
        pick = ptr;
        for (int k = NUM_WORKERS - 1; k >= 0; k--)
            if (bus.req[(int'(ptr) + k) % NUM_WORKERS])
                pick = IW'((int'(ptr) + k) % NUM_WORKERS);
    end
    always_comb begin
        state_n = (state == IDLE) ? (|bus.req ? WRITE : IDLE) : (bus.mem_ready ? IDLE : WRITE);
    end
    always_ff @(posedge wr_clk) begin
        if (!wr_n_rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    assign accept   = (state == WRITE) && bus.mem_ready;
    assign last     = pc == ADDR_W'(FRAME_PIXELS - 1);
    assign win_next = (win == IW'(NUM_WORKERS - 1)) ? '0 : win + 1'b1;
    always_ff @(posedge wr_clk) begin
        if (!wr_n_rst) begin
            ptr    <= '0;
            win    <= '0;
            addr_q <= '0;
            data_q <= '0;
            pc     <= '0;
        end else begin
            if (state == IDLE && |bus.req) begin
                win    <= pick;
                addr_q <= bus.req_addr[int'(pick) * ADDR_W +: ADDR_W];
                data_q <= bus.req_data[int'(pick) * DATA_W +: DATA_W];
            end
            // A frame start overrides a coincident accept: that write completes uncounted.
            if (wr_frame_start) begin
                ptr <= '0;
                pc  <= '0;
            end else if (accept) begin
                ptr <= win_next;
                pc  <= last ? '0 : pc + 1'b1;
            end
        end
    end
    assign bus.mem_wr_en   = state == WRITE;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_data    = data_q;
    assign bus.pixel_count = pc;
    assign bus.grant       = accept ? NUM_WORKERS'(1) << win : '0;
    assign bus.frame_done  = accept && last && !wr_frame_start;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed self-checking bench for wb_rr_arbiter (FRAME_PIXELS=4)
module tb_wb_rr_arbiter;
    localparam int NW = 16;
    localparam int AW = 19;
    localparam int DW = 8;
    logic clk, n_rst, fs;
    int   checks, errors;
    logic [NW-1:0] g_last;
    wb_rr_arbiter_if #(.NUM_WORKERS(NW), .ADDR_W(AW), .DATA_W(DW)) bus ();
    wb_rr_arbiter #(.NUM_WORKERS(NW), .ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(4)) dut (
        .wr_clk(clk),
        .wr_n_rst(n_rst),
        .wr_frame_start(fs),
        .bus(bus)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic frame_clear();
        step();
        fs = 1'b1;
        @(negedge clk);
        step();
        fs = 1'b0;
        @(negedge clk);
        check("fs_clear_pc", 32'(bus.pixel_count), 0);
    endtask
    task automatic serve(input int idx, input logic f, input logic exp_done, input int exp_pc);
        step();
        bus.req = NW'(1) << idx;
        @(negedge clk);
        step();
        fs = f;
        @(negedge clk);
        check("serve_grant", 32'(bus.grant), 32'(NW'(1) << idx));
        check("serve_done", 32'(bus.frame_done), 32'(exp_done));
        step();
        bus.req = '0;
        fs = 1'b0;
        @(negedge clk);
        check("serve_pc", 32'(bus.pixel_count), 32'(exp_pc));
    endtask
    initial begin
        checks = 0;
        errors = 0;
        fs = 1'b0;
        n_rst = 1'b0;
        bus.req = '1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < NW; i++) begin
            bus.req_addr[i*AW +: AW] = AW'(32'h100 + i);
            bus.req_data[i*DW +: DW] = DW'(8'hA0 + i);
        end
        bus.req_addr[5*AW +: AW] = 19'h00123;
        bus.req_data[5*DW +: DW] = 8'h3F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(bus.mem_wr_en), 0);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_pc", 32'(bus.pixel_count), 0);
        check("rst_addr", 32'(bus.mem_addr), 0);
        step();
        n_rst = 1'b1;
        bus.req = 16'h0020;
        @(negedge clk);
        check("single_idle", 32'(bus.mem_wr_en), 0);
        step();
        @(negedge clk);
        check("single_wr_en", 32'(bus.mem_wr_en), 1);
        check("single_addr", 32'(bus.mem_addr), 32'h00123);
        check("single_data", 32'(bus.mem_data), 32'h3F);
        check("single_grant", 32'(bus.grant), 32'h0020);
        step();
        bus.req = '0;
        @(negedge clk);
        check("single_pc", 32'(bus.pixel_count), 1);
        check("single_wr_en_off", 32'(bus.mem_wr_en), 0);
        bus.req_addr[5*AW +: AW] = 19'h00105;
        bus.req_data[5*DW +: DW] = 8'hA5;
        frame_clear();
        step();
        bus.req = '1;
        @(negedge clk);
        g_last = '0;
        for (int c = 0; c < 32; c++) begin
            step();
            bus.req = bus.req & ~g_last;
            @(negedge clk);
            g_last = bus.grant;
            check("full_grant", 32'(bus.grant), (c % 2 == 0) ? 32'(1) << (c / 2) : 0);
            check("full_done", 32'(bus.frame_done), 32'((c % 2 == 0) && ((c / 2) % 4 == 3)));
            if (c % 2 == 0)
                check("full_addr", 32'(bus.mem_addr), 32'h100 + c / 2);
        end
        check("full_pc", 32'(bus.pixel_count), 0);
        step();
        bus.req = 16'h4001;
        @(negedge clk);
        check("wrap_idle", 32'(bus.grant), 0);
        step();
        @(negedge clk);
        check("wrap_first", 32'(bus.grant), 32'h0001);
        step();
        bus.req = 16'h4000;
        @(negedge clk);
        check("wrap_gap", 32'(bus.grant), 0);
        step();
        @(negedge clk);
        check("wrap_second", 32'(bus.grant), 32'h4000);
        check("wrap_addr", 32'(bus.mem_addr), 32'h10E);
        step();
        bus.req = 16'h0008;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("bp_pc", 32'(bus.pixel_count), 2);
        for (int k = 0; k < 4; k++) begin
            step();
            bus.mem_ready = (k == 3);
            @(negedge clk);
            check("bp_wr_en", 32'(bus.mem_wr_en), 1);
            check("bp_addr", 32'(bus.mem_addr), 32'h103);
            check("bp_data", 32'(bus.mem_data), 32'hA3);
            check("bp_grant", 32'(bus.grant), (k == 3) ? 32'h0008 : 0);
        end
        step();
        bus.req = '0;
        @(negedge clk);
        check("bp_release", 32'(bus.mem_wr_en), 0);
        check("bp_pc_after", 32'(bus.pixel_count), 3);
        frame_clear();
        serve(7, 1'b0, 1'b0, 1);
        serve(2, 1'b0, 1'b0, 2);
        serve(9, 1'b0, 1'b0, 3);
        serve(4, 1'b0, 1'b1, 0);
        serve(1, 1'b0, 1'b0, 1);
        serve(6, 1'b0, 1'b0, 2);
        serve(11, 1'b0, 1'b0, 3);
        serve(12, 1'b1, 1'b0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
